// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter: N AXI-Stream requesters share one sink.
// A grant is held from the first beat through TLast, so packets never interleave.
module axis_rr_arbiter #(
    parameter int N     = 4,
    parameter int width = 8
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [N*width-1:0] S_TData,
    input  logic [N-1:0]       S_TValid,
    input  logic [N-1:0]       S_TLast,
    output logic [N-1:0]       S_TReady,
    output logic [width-1:0]   M_TData,
    output logic               M_TValid,
    output logic               M_TLast,
    input  logic               M_TReady,
    input  logic [N-1:0]       Enable,
    output logic [N-1:0]       Grant,
    output logic               Busy,
    output logic               PktDone
);

    // state     | meaning
    // ST_IDLE   | no owner; pick next enabled requester after last_owner_q
    // ST_LOCKED | owner_q's packet passes through until its TLast handshake

    localparam int OW = $clog2(N);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t        state_q;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] last_owner_q;
    logic          pkt_done_q;

    logic [N-1:0]  cand;
    logic [OW-1:0] owner_d;
    logic          found_d;
    logic [OW:0]   sum;
    logic [OW-1:0] idx;
    logic          last_beat;

    assign cand = S_TValid & Enable;

    // Search wraps from last_owner_q+1; the extra bit of sum absorbs the carry before the wrap.
    always_comb begin
        found_d = 1'b0;
        owner_d = owner_q;
        sum     = '0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, last_owner_q} + (OW+1)'(k);
            if (sum >= (OW+1)'(N)) begin
                sum = sum - (OW+1)'(N);
            end
            idx = sum[OW-1:0];
            if (!found_d && cand[idx]) begin
                found_d = 1'b1;
                owner_d = idx;
            end
        end
    end

    always_comb begin
        M_TData  = '0;
        M_TValid = 1'b0;
        M_TLast  = 1'b0;
        S_TReady = '0;
        Grant    = '0;
        if (state_q == ST_LOCKED) begin
            for (int i = 0; i < N; i++) begin
                if (owner_q == OW'(i)) begin
                    M_TData     = S_TData[i*width +: width];
                    M_TValid    = S_TValid[i];
                    M_TLast     = S_TLast[i];
                    S_TReady[i] = M_TReady;
                    Grant[i]    = 1'b1;
                end
            end
        end
    end

    assign last_beat = M_TValid & M_TReady & M_TLast;
    assign Busy      = (state_q == ST_LOCKED);
    assign PktDone   = pkt_done_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(N-1);
            pkt_done_q   <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        owner_q <= owner_d;
                        state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (last_beat) begin
                        state_q      <= ST_IDLE;
                        last_owner_q <= owner_q;
                        pkt_done_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: per-requester packet sources, expected
// beats queued with owner and cycle, checked by an independent output monitor.
module tb_axis_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic             CLK = 1'b0;
    logic             Reset;
    logic [N*W-1:0]   S_TData;
    logic [N-1:0]     S_TValid;
    logic [N-1:0]     S_TLast;
    logic [N-1:0]     S_TReady;
    logic [W-1:0]     M_TData;
    logic             M_TValid;
    logic             M_TLast;
    logic             M_TReady;
    logic [N-1:0]     Enable;
    logic [N-1:0]     Grant;
    logic             Busy;
    logic             PktDone;

    axis_rr_arbiter #(.N(N), .width(W)) dut (
        .CLK(CLK), .Reset(Reset),
        .S_TData(S_TData), .S_TValid(S_TValid), .S_TLast(S_TLast), .S_TReady(S_TReady),
        .M_TData(M_TData), .M_TValid(M_TValid), .M_TLast(M_TLast), .M_TReady(M_TReady),
        .Enable(Enable), .Grant(Grant), .Busy(Busy), .PktDone(PktDone)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         owner;
        logic [7:0] data;
        logic       last;
        int         cyc;
    } beat_t;

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         k;
    logic       armed = 1'b0;
    beat_t      exp_q[$];
    beat_t      mon_e;
    logic [8:0] src_q[N][$];
    logic [N-1:0] stall = '0;
    logic [N-1:0] fire;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic src_pkt(input int req, input int base, input int n);
        for (int b = 0; b < n; b++) src_q[req].push_back({(b == n-1), 8'(base + b)});
    endtask

    task automatic exp_beat(input int req, input int data, input logic last, input int c);
        beat_t e;
        e.owner = req;
        e.data  = 8'(data);
        e.last  = last;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic exp_pkt(input int req, input int base, input int n, input int c0);
        for (int b = 0; b < n; b++) exp_beat(req, base + b, (b == n-1), c0 + b);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("drain", exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge CLK); #1 Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
    endtask

    // Requester model: present queue heads, retire a beat after its handshake edge.
    initial begin
        S_TValid = '0;
        S_TLast  = '0;
        S_TData  = '0;
        forever begin
            @(negedge CLK);
            fire = Reset ? '0 : (S_TValid & S_TReady);
            @(posedge CLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                if (src_q[i].size() != 0 && !stall[i]) begin
                    S_TValid[i]        = 1'b1;
                    S_TLast[i]         = src_q[i][0][8];
                    S_TData[i*W +: W]  = src_q[i][0][7:0];
                end else begin
                    S_TValid[i]        = 1'b0;
                    S_TLast[i]         = 1'b0;
                    S_TData[i*W +: W]  = '0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (armed) check("s_tready", S_TReady, {N{M_TReady}} & Grant);
        if (armed && !Reset && M_TValid && M_TReady) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got data 0x%0h grant 0x%0h, expected no beat (cycle %0d)",
                         M_TData, Grant, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", M_TData, mon_e.data);
                check("beat_last", M_TLast, mon_e.last);
                check("beat_owner", Grant, 32'(1) << mon_e.owner);
                if (mon_e.cyc >= 0) check("beat_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        M_TReady = 1'b1;
        Enable   = '1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        armed = 1'b1;
        check("rst_grant", Grant, 0);
        check("rst_busy", Busy, 0);
        check("rst_pktdone", PktDone, 0);
        check("rst_mvalid", M_TValid, 0);
        check("rst_mlast", M_TLast, 0);
        check("rst_mdata", M_TData, 0);
        check("rst_sready", S_TReady, 0);
        @(posedge CLK); #1 Reset = 1'b0;

        // single 3-beat packet from requester 2
        @(negedge CLK);
        k = cyc + 1;
        src_pkt(2, 8'hA1, 3);
        exp_pkt(2, 8'hA1, 3, k + 1);
        @(negedge CLK); check("t1_grant_idle", Grant, 0);
        @(negedge CLK); check("t1_grant", Grant, 4'b0100);
        check("t1_pktdone_early", PktDone, 0);
        @(negedge CLK);
        @(negedge CLK); check("t1_pktdone_last", PktDone, 0);
        @(negedge CLK); check("t1_pktdone_pulse", PktDone, 1);
        check("t1_grant_after", Grant, 0);
        @(negedge CLK); check("t1_pktdone_clear", PktDone, 0);

        // fairness: all four requesters, 3 cycles per 2-beat packet
        do_reset();
        @(negedge CLK);
        k = cyc + 1;
        src_pkt(0, 8'h00, 2); src_pkt(0, 8'h08, 2);
        src_pkt(1, 8'h10, 2); src_pkt(2, 8'h20, 2); src_pkt(3, 8'h30, 2);
        exp_pkt(0, 8'h00, 2, k + 1);
        exp_pkt(1, 8'h10, 2, k + 4);
        exp_pkt(2, 8'h20, 2, k + 7);
        exp_pkt(3, 8'h30, 2, k + 10);
        exp_pkt(0, 8'h08, 2, k + 13);
        wait_drain(40);

        // backpressure on requester 1 mid-packet, requester 2 waiting
        @(negedge CLK);
        k = cyc + 1;
        src_pkt(1, 8'hB0, 4);
        src_pkt(2, 8'hC0, 2);
        exp_beat(1, 8'hB0, 1'b0, k + 1);
        exp_beat(1, 8'hB1, 1'b0, k + 2);
        exp_beat(1, 8'hB2, 1'b0, k + 8);
        exp_beat(1, 8'hB3, 1'b1, k + 9);
        exp_pkt(2, 8'hC0, 2, k + 11);
        repeat (3) @(negedge CLK);
        @(posedge CLK); #1 M_TReady = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            check("t3_sready", S_TReady, 0);
            check("t3_grant", Grant, 4'b0010);
            check("t3_data_hold", M_TData, 8'hB2);
            check("t3_valid_hold", M_TValid, 1);
        end
        @(posedge CLK); #1 M_TReady = 1'b1;
        wait_drain(30);

        // enable mask 1010: 1,3,1; Enable[3] cleared while 3 is locked
        do_reset();
        Enable = 4'b1010;
        @(negedge CLK);
        k = cyc + 1;
        src_pkt(0, 8'h40, 3);
        src_pkt(1, 8'h50, 3); src_pkt(1, 8'h58, 3);
        src_pkt(2, 8'h60, 3);
        src_pkt(3, 8'h70, 3); src_pkt(3, 8'h78, 3);
        exp_pkt(1, 8'h50, 3, k + 1);
        exp_pkt(3, 8'h70, 3, k + 5);
        exp_pkt(1, 8'h58, 3, k + 9);
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (Grant == 4'b1000) break;
        end
        check("t4_grant3", Grant, 4'b1000);
        @(posedge CLK); #1 Enable = 4'b0010;
        wait_drain(30);
        repeat (3) begin
            @(negedge CLK);
            check("t4_masked_idle", Grant, 0);
        end
        k = cyc + 1;
        exp_pkt(2, 8'h60, 3, k + 1);
        exp_pkt(3, 8'h78, 3, k + 5);
        exp_pkt(0, 8'h40, 3, k + 9);
        @(posedge CLK); #1 Enable = 4'b1111;
        wait_drain(40);

        // owner stalls 4 cycles mid-packet while others request
        @(negedge CLK);
        k = cyc + 1;
        src_pkt(1, 8'h90, 4);
        src_pkt(2, 8'hA8, 1);
        src_pkt(3, 8'hB8, 1);
        exp_beat(1, 8'h90, 1'b0, k + 1);
        exp_beat(1, 8'h91, 1'b0, k + 2);
        exp_beat(1, 8'h92, 1'b0, k + 7);
        exp_beat(1, 8'h93, 1'b1, k + 8);
        exp_beat(2, 8'hA8, 1'b1, k + 10);
        exp_beat(3, 8'hB8, 1'b1, k + 12);
        repeat (3) @(negedge CLK);
        stall[1] = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            check("t5_mvalid", M_TValid, 0);
            check("t5_busy", Busy, 1);
            check("t5_grant", Grant, 4'b0010);
        end
        stall[1] = 1'b0;
        wait_drain(30);

        // reset on beat 2 of requester 0's 4-beat packet
        @(negedge CLK);
        k = cyc + 1;
        src_pkt(0, 8'hD0, 4);
        src_pkt(1, 8'hF0, 2);
        exp_beat(0, 8'hD0, 1'b0, k + 1);
        repeat (2) @(negedge CLK);
        @(posedge CLK); #1 Reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("t6_grant", Grant, 0);
        check("t6_mvalid", M_TValid, 0);
        check("t6_busy", Busy, 0);
        check("t6_mlast", M_TLast, 0);
        src_q[0].delete();
        src_pkt(0, 8'hE0, 2);
        exp_pkt(0, 8'hE0, 2, k + 5);
        exp_pkt(1, 8'hF0, 2, k + 8);
        @(posedge CLK); #1 Reset = 1'b0;
        wait_drain(30);

        repeat (3) @(negedge CLK);
        check("final_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
